// File: rtl/sat_accum_16bit.sv
// Saturating multi-operand accumulator: folds a burst of 1..15 signed 16-bit
// operands into one result using the ALU's per-step add/sub saturation rules.
module sat_accum_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  len,
  input  logic [15:0] init,
  input  logic        sub,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        ovfl
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state;
  logic [15:0] acc;
  logic [3:0]  cnt;
  logic [3:0]  len_q;
  logic        sub_q;

  logic [15:0] operand;
  logic [16:0] sum;
  logic        carry_in15;
  logic        step_ovf;
  logic [15:0] sat_sum;

  // Subtract is acc + ~data + 1; overflow is carry into bit 15 XOR carry out.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    operand    = sub_q ? ~in_data : in_data;
    sum        = {1'b0, acc} + {1'b0, operand} + {16'd0, sub_q};
    carry_in15 = acc[15] ^ operand[15] ^ sum[15];
    step_ovf   = carry_in15 ^ sum[16];
    sat_sum    = sum[15:0];
    // Overflow only occurs when the rail direction matches the accumulator sign.
    if (step_ovf) sat_sum = acc[15] ? 16'h8000 : 16'h7FFF;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= 16'h0000;
      ovfl  <= 1'b0;
      cnt   <= 4'd0;
      len_q <= 4'd0;
      sub_q <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc   <= init;
            sub_q <= sub;
            len_q <= len;
            ovfl  <= 1'b0;
            cnt   <= 4'd0;
            state <= (len == 4'd0) ? ST_DONE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            acc  <= sat_sum;
            ovfl <= ovfl | step_ovf;
            cnt  <= cnt + 4'd1;
            if (cnt == len_q - 4'd1) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready = (state == ST_ACCUM);
  assign busy     = (state == ST_ACCUM) || (state == ST_DONE);
  assign done     = (state == ST_DONE);
  assign result   = acc;

endmodule

// File: tb/tb_sat_accum_16bit.sv
// Directed self-checking bench for sat_accum_16bit with hand-computed results.
module tb_sat_accum_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  len = 4'd0;
  logic [15:0] init = 16'h0000;
  logic        sub = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_ready, busy, done, ovfl;
  logic [15:0] result;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] vec [0:15];

  sat_accum_16bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .init(init),
    .sub(sub), .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done), .result(result), .ovfl(ovfl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [15:0] iv, input logic [3:0] ln, input logic sb);
    start = 1'b1; init = iv; len = ln; sub = sb;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_final(input string tag, input logic [15:0] res, input logic ov);
    chk({tag, "_done"}, {15'd0, done}, 16'd1);
    chk({tag, "_result"}, result, res);
    chk({tag, "_ovfl"}, {15'd0, ovfl}, {15'd0, ov});
  endtask

  initial begin
    logic [6:0] pat;
    int k;

    // Reset state
    #12;
    chk("rst_result", result, 16'h0000);
    chk("rst_ovfl", {15'd0, ovfl}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_ready", {15'd0, in_ready}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    rst_n = 1'b1;
    step();

    // Basic add: 1 + 2 + 3 + 4
    start_burst(16'h0001, 4'd3, 1'b0);
    chk("add_ready", {15'd0, in_ready}, 16'd1);
    chk("add_busy", {15'd0, busy}, 16'd1);
    vec[0] = 16'h0002; vec[1] = 16'h0003; vec[2] = 16'h0004;
    feed(3);
    check_final("add", 16'h000A, 1'b0);
    // start during the done cycle is ignored
    start_burst(16'hBEEF, 4'd0, 1'b0);
    chk("done_start_done", {15'd0, done}, 16'd0);
    chk("done_start_busy", {15'd0, busy}, 16'd0);
    chk("done_start_result", result, 16'h000A);

    // Positive saturation then recovery
    start_burst(16'h7FF0, 4'd2, 1'b0);
    in_valid = 1'b1; in_data = 16'h0020;
    step();
    chk("psat_mid_result", result, 16'h7FFF);
    chk("psat_mid_ovfl", {15'd0, ovfl}, 16'd1);
    in_data = 16'hFFFF;
    step();
    in_valid = 1'b0;
    check_final("psat", 16'h7FFE, 1'b1);
    step();

    // Subtract rails
    vec[0] = 16'h8000;
    start_burst(16'h0000, 4'd1, 1'b1); feed(1);
    check_final("sub0", 16'h7FFF, 1'b1);
    step();
    vec[0] = 16'h0001;
    start_burst(16'h8000, 4'd1, 1'b1); feed(1);
    check_final("sub1", 16'h8000, 1'b1);
    step();

    // len=0 directly after an overflowing burst: ovfl must clear
    start_burst(16'h1234, 4'd0, 1'b0);
    check_final("len0", 16'h1234, 1'b0);
    step();

    vec[0] = 16'h8000;
    start_burst(16'h8000, 4'd1, 1'b1); feed(1);
    check_final("sub2", 16'h0000, 1'b0);
    step();

    // Backpressure: in_valid 1,0,0,1,1,0,1 and a stray start mid-burst
    pat = 7'b1011001;
    k = 0;
    start_burst(16'h0000, 4'd4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("bp_ready%0d", i), {15'd0, in_ready}, 16'd1);
      in_valid = pat[i];
      in_data  = pat[i] ? 16'(k + 1) : 16'hDEAD;
      start    = (i == 1);
      init     = 16'h5555;
      len      = 4'd0;
      if (pat[i]) k++;
      step();
      start = 1'b0;
      if (i < 6) chk($sformatf("bp_nodone%0d", i), {15'd0, done}, 16'd0);
    end
    in_valid = 1'b0;
    check_final("bp", 16'h000A, 1'b0);
    step();

    // Abort after 2 of 5 operands, with an operand offered in the abort cycle
    vec[0] = 16'h0010; vec[1] = 16'h0020;
    start_burst(16'h0000, 4'd5, 1'b0);
    feed(2);
    abort = 1'b1; in_valid = 1'b1; in_data = 16'h0100;
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_ready", {15'd0, in_ready}, 16'd0);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_done", {15'd0, done}, 16'd0);
    chk("abort_result", result, 16'h0030);
    step();
    chk("abort_done2", {15'd0, done}, 16'd0);
    vec[0] = 16'h0001;
    start_burst(16'h0100, 4'd1, 1'b0); feed(1);
    check_final("post_abort", 16'h0101, 1'b0);
    step();

    // Async reset mid-burst, between clock edges
    vec[0] = 16'h0001;
    start_burst(16'h7FFF, 4'd3, 1'b0); feed(1);
    chk("pre_rst_ovfl", {15'd0, ovfl}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_result", result, 16'h0000);
    chk("arst_ovfl", {15'd0, ovfl}, 16'd0);
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_ready", {15'd0, in_ready}, 16'd0);
    chk("arst_done", {15'd0, done}, 16'd0);
    step();
    #3;
    rst_n = 1'b1;
    step();
    vec[0] = 16'h0002; vec[1] = 16'hFFFF;
    start_burst(16'hFFFE, 4'd2, 1'b1); feed(2);
    check_final("post_rst", 16'hFFFD, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
